// File: rtl/nack_skid.sv
// Skid buffer: ring storage, registered output stage, registered upstream Nack with hysteresis.
// Optional downstream-stall cycle counter is built only when NACK_SKID_STAT_EN is defined.
package nack_skid_pkg;
    typedef struct packed {
        logic       v;
        logic [7:0] d;
    } FTk_t;

    typedef struct packed {
        logic n;
        logic t;
        logic v;
        logic c;
    } BTk_t;
endpackage

module nack_skid #(
    parameter int  DEPTH_SKID = 8,
    parameter int  THRESHOLD  = 2,
    parameter type TYPE_FWRD  = nack_skid_pkg::FTk_t
) (
    input  logic                clk,
    input  logic                rst_n,
    input  TYPE_FWRD            I_FTk,
    output nack_skid_pkg::BTk_t O_BTk,
    output TYPE_FWRD            O_FTk,
    input  nack_skid_pkg::BTk_t I_BTk,
    output logic                O_Empty,
    output logic                O_Full,
    output logic                O_Ovf,
    output logic [15:0]         O_StallCnt
);
    // state | meaning
    // IDLE  | storage and output register empty
    // RUN   | forwarding tokens
    // STALL | downstream stalling, output held
    // THROT | upstream Nack asserted, draining
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_THROT = 2'd3
    } state_t;

    localparam int PTR_W = $clog2(DEPTH_SKID);
    localparam int NUM_W = PTR_W + 1;
    localparam logic [NUM_W-1:0] NUM_FULL = NUM_W'(DEPTH_SKID);
    localparam logic [NUM_W-1:0] NUM_HI   = NUM_W'(DEPTH_SKID - 2);
    localparam logic [NUM_W-1:0] NUM_LO   = NUM_W'(THRESHOLD);

    TYPE_FWRD         mem_q [DEPTH_SKID];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [NUM_W-1:0] num_q, num_d;
    TYPE_FWRD         out_q, out_d;
    logic             nack_q, nack_d;
    logic             ovf_q, ovf_d;
    state_t           state_q, state_d;
    logic             rd_en, wr_en;

    always_comb begin
        rd_en    = (num_q != '0) && (!out_q.v || !I_BTk.n);
        wr_en    = I_FTk.v && ((num_q != NUM_FULL) || rd_en);
        wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        num_d    = num_q + NUM_W'(wr_en) - NUM_W'(rd_en);
        ovf_d    = ovf_q | (I_FTk.v & ~wr_en);

        out_d = out_q;
        if (rd_en) begin
            out_d = mem_q[rd_ptr_q];
        end else if (!I_BTk.n) begin
            // consumed with nothing stored behind it
            out_d.v = 1'b0;
        end

        nack_d = nack_q;
        if (num_q >= NUM_HI) begin
            nack_d = 1'b1;
        end else if (num_q < NUM_LO) begin
            nack_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (I_FTk.v) state_d = ST_RUN;
            ST_RUN: begin
                if (nack_q)                    state_d = ST_THROT;
                else if (I_BTk.n && out_q.v)   state_d = ST_STALL;
                else if (num_q == '0 && !out_q.v) state_d = ST_IDLE;
            end
            ST_STALL: begin
                if (nack_q)        state_d = ST_THROT;
                else if (!I_BTk.n) state_d = ST_RUN;
            end
            ST_THROT: if (!nack_q) state_d = ST_RUN;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            num_q    <= '0;
            out_q    <= '0;
            nack_q   <= 1'b0;
            ovf_q    <= 1'b0;
            state_q  <= ST_IDLE;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            num_q    <= num_d;
            out_q    <= out_d;
            nack_q   <= nack_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
        end
    end

    // payload storage needs no reset; occupancy decides what is live
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= I_FTk;
    end

`ifdef NACK_SKID_STAT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (I_BTk.n && out_q.v && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign O_StallCnt = stall_cnt_q;
`else
    assign O_StallCnt = 16'd0;
`endif

    assign O_BTk.n = nack_q;
    assign O_BTk.t = I_BTk.t;
    assign O_BTk.v = I_BTk.v;
    assign O_BTk.c = I_BTk.c;
    assign O_FTk   = out_q;
    assign O_Empty = (num_q == '0) & ~out_q.v;
    assign O_Full  = (num_q == NUM_FULL);
    assign O_Ovf   = ovf_q;
endmodule

// File: tb/tb_nack_skid.sv
// Randomized bench for nack_skid against a queue-level reference model, plus directed literal checks.
module tb_nack_skid;
    import nack_skid_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    FTk_t        i_ftk, o_ftk;
    BTk_t        i_btk, o_btk;
    logic        o_empty, o_full, o_ovf;
    logic [15:0] o_stallcnt;

    int n_chk = 0;
    int n_fail = 0;

    FTk_t mq[$];
    FTk_t m_out;
    bit   m_nack, m_ovf;
    int   m_cnt;

`ifdef NACK_SKID_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    always #5 clk = ~clk;

    nack_skid dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .I_FTk      (i_ftk),
        .O_BTk      (o_btk),
        .O_FTk      (o_ftk),
        .I_BTk      (i_btk),
        .O_Empty    (o_empty),
        .O_Full     (o_full),
        .O_Ovf      (o_ovf),
        .O_StallCnt (o_stallcnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("o_ftk_v", 32'(o_ftk.v), 32'(m_out.v));
        if (m_out.v) check("o_ftk_d", 32'(o_ftk.d), 32'(m_out.d));
        check("o_btk_n", 32'(o_btk.n), 32'(m_nack));
        check("o_btk_tvc", 32'({o_btk.t, o_btk.v, o_btk.c}), 32'({i_btk.t, i_btk.v, i_btk.c}));
        check("o_empty", 32'(o_empty), 32'(mq.size() == 0 && !m_out.v));
        check("o_full", 32'(o_full), 32'(mq.size() == 8));
        check("o_ovf", 32'(o_ovf), 32'(m_ovf));
        check("o_stallcnt", 32'(o_stallcnt), STAT ? 32'(m_cnt) : 32'd0);
    endtask

    // One clock of the reference: queue of stored tokens plus one output slot.
    task automatic model_step();
        int sz;
        bit rd, wr;
        sz = mq.size();
        rd = (sz > 0) && (!m_out.v || !i_btk.n);
        wr = i_ftk.v && (sz < 8 || rd);
        if (i_ftk.v && !wr) m_ovf = 1'b1;
        if (i_btk.n && m_out.v && m_cnt < 65535) m_cnt++;
        if (sz >= 6) m_nack = 1'b1;
        else if (sz < 2) m_nack = 1'b0;
        if (rd) m_out = mq.pop_front();
        else if (!i_btk.n) m_out.v = 1'b0;
        if (wr) mq.push_back(i_ftk);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input bit v, input logic [7:0] d, input bit n);
        i_ftk.v = v;
        i_ftk.d = d;
        i_btk.n = n;
        i_btk.t = 1'($urandom);
        i_btk.v = 1'($urandom);
        i_btk.c = 1'($urandom);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        i_btk = '0;
        i_ftk = '0;
        #1;
        check("rst_o_ftk", 32'(o_ftk), 32'd0);
        check("rst_o_btk", 32'(o_btk), 32'd0);
        check("rst_o_empty", 32'(o_empty), 32'd1);
        check("rst_o_full", 32'(o_full), 32'd0);
        check("rst_o_ovf", 32'(o_ovf), 32'd0);
        check("rst_o_stallcnt", 32'(o_stallcnt), 32'd0);
        mq.delete();
        m_out  = '0;
        m_nack = 1'b0;
        m_ovf  = 1'b0;
        m_cnt  = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int pv, pn;
        i_ftk = '0;
        i_btk = '0;

        // three consecutive tokens, no stall
        do_reset();
        drive(1'b1, 8'hA1, 1'b0); step();
        drive(1'b1, 8'hB2, 1'b0); step();
        check("lat_a", 32'(o_ftk), 32'h1A1);
        drive(1'b1, 8'hC3, 1'b0); step();
        check("lat_b", 32'(o_ftk), 32'h1B2);
        drive(1'b0, 8'h00, 1'b0); step();
        check("lat_c", 32'(o_ftk), 32'h1C3);
        step();
        check("drained_empty", 32'(o_empty), 32'd1);

        // fill under stall, Nack timing, full, overflow, stall count, drain
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            drive(1'b1, 8'(k), 1'b1); step();
            if (k == 7) check("nack_before", 32'(o_btk.n), 32'd0);
            if (k == 8) check("nack_after", 32'(o_btk.n), 32'd1);
        end
        check("full_set", 32'(o_full), 32'd1);
        check("hold_tok1", 32'(o_ftk), 32'h101);
        check("no_ovf_yet", 32'(o_ovf), 32'd0);
        drive(1'b1, 8'd10, 1'b1); step();
        check("ovf_set", 32'(o_ovf), 32'd1);
        drive(1'b0, 8'd0, 1'b1); step();
        step();
        check("stallcnt_10", 32'(o_stallcnt), STAT ? 32'd10 : 32'd0);
        drive(1'b0, 8'd0, 1'b0);
        repeat (10) step();
        check("drain_empty", 32'(o_empty), 32'd1);
        check("drain_nack", 32'(o_btk.n), 32'd0);
        check("ovf_sticky", 32'(o_ovf), 32'd1);

        // randomized phases with varying input and stall pressure
        do_reset();
        for (int ph = 0; ph < 12; ph++) begin
            pv = $urandom_range(20, 100);
            pn = $urandom_range(0, 90);
            if (ph == 6) do_reset();
            for (int c = 0; c < 250; c++) begin
                drive($urandom_range(0, 99) < pv, 8'($urandom), $urandom_range(0, 99) < pn);
                step();
            end
        end

        // mid-stream reset must clear everything asynchronously
        drive(1'b1, 8'h55, 1'b1); step();
        do_reset();
        drive(1'b0, 8'h00, 1'b0); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
